// File: rtl/wavefront_pkg.sv
// wavefront_pkg: mode encoding, per-channel delay and counter-width helpers
// shared by the wavefront skew unit and its delay lines.
package wavefront_pkg;

    typedef enum int {WF_SKEW = 0, WF_DESKEW = 1} wf_mode_e;

    typedef logic [15:0] wf_cnt_t;

    function automatic int chan_delay(input int i, input int n, input int mode);
        return (mode == WF_DESKEW) ? n - 1 - i : i;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vdelay.sv
// vdelay: D-stage delay line carrying a valid bit with each data word;
// D = 0 degenerates to a combinational passthrough.
module vdelay #(
    parameter int DATA_WIDTH = 8,
    parameter int D          = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  vin,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  vout,
    output logic [DATA_WIDTH-1:0] dout
);

    if (D == 0) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ rst_n;
        assign vout     = vin & en & ~flush;
        assign dout     = din;
    end else begin : g_line
        logic [D-1:0]          r_v;
        logic [DATA_WIDTH-1:0] r_d [0:D-1];
        // flush only drops valid bits; stale data is harmless once invalid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= '0;
                for (int k = 0; k < D; k++) r_d[k] <= '0;
            end else if (flush) begin
                r_v <= '0;
            end else if (en) begin
                r_v[0] <= vin;
                r_d[0] <= din;
                for (int k = 1; k < D; k++) begin
                    r_v[k] <= r_v[k-1];
                    r_d[k] <= r_d[k-1];
                end
            end
        end
        assign vout = r_v[D-1] & en;
        assign dout = r_d[D-1];
    end

endmodule

// File: rtl/wavefront_skew_unit.sv
// wavefront_skew_unit: N-channel skew/deskew stage with valid tracking, stall, flush
// and an in-flight wavefront counter. Define WAVEFRONT_ZERO_BUBBLE_EN to zero invalid slots.
module wavefront_skew_unit
    import wavefront_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   din [0:N-1],
    output logic [DATA_WIDTH-1:0]   dout [0:N-1],
    output logic [N-1:0]            dout_valid,
    output logic [cnt_width(N)-1:0] inflight,
    output logic                    busy
);

    localparam int CW = cnt_width(N);

    logic [DATA_WIDTH-1:0] w_d [0:N-1];
    logic [N-1:0]          w_v;

    genvar i;
    for (i = 0; i < N; i++) begin : g_ch
        vdelay #(
            .DATA_WIDTH(DATA_WIDTH),
            .D         (chan_delay(i, N, MODE))
        ) u_dly (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .flush(flush),
            .vin  (in_valid),
            .din  (din[i]),
            .vout (w_v[i]),
            .dout (w_d[i])
        );
`ifdef WAVEFRONT_ZERO_BUBBLE_EN
        assign dout[i] = w_v[i] ? w_d[i] : '0;
`else
        assign dout[i] = w_d[i];
`endif
    end

    assign dout_valid = w_v;

    if (N == 1) begin : g_nocnt
        assign inflight = '0;
    end else begin : g_cnt
        localparam int MAX_CH = (MODE == WF_DESKEW) ? 0 : N - 1;
        logic          w_acc;
        logic          w_dec;
        logic [CW-1:0] r_inflight;
        assign w_acc = in_valid & en & ~flush;
        assign w_dec = w_v[MAX_CH];
        // a wavefront retires when its slowest channel emits
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_inflight <= '0;
            else if (flush)
                r_inflight <= '0;
            else if (w_acc != w_dec)
                r_inflight <= w_acc ? r_inflight + CW'(1) : r_inflight - CW'(1);
        end
        assign inflight = r_inflight;
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(!flush && w_dec && !w_acc && r_inflight == '0));
    end

    assign busy = |inflight;

endmodule

// File: tb/tb_wavefront_skew_unit.sv
// tb_wavefront_skew_unit: SKEW and DESKEW instances (N=4) driven by directed vectors;
// a queue-based scoreboard is checked by a negedge monitor.
module tb_wavefront_skew_unit;
    import wavefront_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk = 0, rst_n = 0, en = 0, flush = 0, iv_s = 0, iv_d = 0;
    logic [7:0] din_s [0:3];
    logic [7:0] din_d [0:3];
    logic [7:0] dout_s [0:3];
    logic [7:0] dout_d [0:3];
    logic [3:0] dv_s, dv_d;
    logic [1:0] inf_s, inf_d;
    logic       busy_s, busy_d;
    logic [1:0] acc_now = 2'b00;
    exp_t       sb [8][$];
    int         ecnt = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    wavefront_skew_unit #(.DATA_WIDTH(8), .N(4), .MODE(0)) u_skew (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(iv_s),
        .din(din_s), .dout(dout_s), .dout_valid(dv_s), .inflight(inf_s), .busy(busy_s)
    );

    wavefront_skew_unit #(.DATA_WIDTH(8), .N(4), .MODE(1)) u_deskew (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(iv_d),
        .din(din_d), .dout(dout_d), .dout_valid(dv_d), .inflight(inf_d), .busy(busy_d)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_sb();
        for (int k = 0; k < 8; k++) sb[k].delete();
    endtask

    // model of the enabled-edge count and flush
    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) clear_sb();
            if (en) ecnt <= ecnt + 1;
        end
    end

    task automatic check_unit(input int u, input logic [3:0] dv, input logic [7:0] dq [0:3],
                              input logic [1:0] inf, input logic b);
        int mc;
        int ei;
        mc = (u == 0) ? 3 : 0;
        ei = sb[u*4+mc].size() - int'(acc_now[u]);
        chk($sformatf("u%0d_inflight@%0t", u, $time), int'(inf), ei);
        chk($sformatf("u%0d_busy@%0t", u, $time), int'(b), int'(ei != 0));
        for (int i = 0; i < 4; i++) begin
            int   k;
            logic ev;
            k  = u * 4 + i;
            ev = (sb[k].size() > 0) && (sb[k][0].due == ecnt) && en;
            chk($sformatf("u%0d_valid%0d@%0t", u, i, $time), int'(dv[i]), int'(ev));
            if (ev) begin
                chk($sformatf("u%0d_data%0d@%0t", u, i, $time), int'(dq[i]), int'(sb[k][0].data));
                void'(sb[k].pop_front());
            end
`ifdef WAVEFRONT_ZERO_BUBBLE_EN
            else chk($sformatf("u%0d_zero%0d@%0t", u, i, $time), int'(dq[i]), 0);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_unit(0, dv_s, dout_s, inf_s, busy_s);
            check_unit(1, dv_d, dout_d, inf_d, busy_d);
        end
    end

    task automatic drive(input logic e, input logic f, input logic vs, input logic [31:0] ws,
                         input logic vd, input logic [31:0] wd);
        exp_t x;
        en    = e;
        flush = f;
        iv_s  = vs;
        iv_d  = vd;
        acc_now = {vd & e & ~f, vs & e & ~f};
        for (int i = 0; i < 4; i++) begin
            din_s[i] = ws[i*8+:8];
            din_d[i] = wd[i*8+:8];
            if (acc_now[0]) begin
                x.data = ws[i*8+:8];
                x.due  = ecnt + i;
                sb[i].push_back(x);
            end
            if (acc_now[1]) begin
                x.data = wd[i*8+:8];
                x.due  = ecnt + 3 - i;
                sb[4+i].push_back(x);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic e, input logic f, input logic vs, input logic [31:0] ws,
                        input logic vd, input logic [31:0] wd);
        drive(e, f, vs, ws, vd, wd);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dv_s"}, int'(dv_s), 0);
        chk({tag, "_dv_d"}, int'(dv_d), 0);
        chk({tag, "_inf_s"}, int'(inf_s), 0);
        chk({tag, "_inf_d"}, int'(inf_d), 0);
        chk({tag, "_busy_s"}, int'(busy_s), 0);
        chk({tag, "_busy_d"}, int'(busy_d), 0);
        for (int i = 1; i < 4; i++) chk($sformatf("%s_dout_s%0d", tag, i), int'(dout_s[i]), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_dout_d%0d", tag, i), int'(dout_d[i]), 0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            din_s[i] = '0;
            din_d[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;

        // skew latency: channel i emits Ai at cycle i
        step(1'b1, 1'b0, 1'b1, 32'hA3A2A1A0, 1'b0, 32'h0);
        idle(5);

        // stall for two cycles after acceptance
        step(1'b1, 1'b0, 1'b1, 32'hB3B2B1B0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(5);

        // bubbles: alternating in_valid
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, (k % 2) == 0, {8'hC3 + 8'(k), 8'hC2 + 8'(k), 8'hC1 + 8'(k), 8'hC0 + 8'(k)},
                 1'b0, 32'h0);
        idle(4);

        // deskew streaming: channel i carries wavefront c-i at cycle c
        for (int c = 0; c < 11; c++) begin
            for (int i = 0; i < 4; i++)
                w[i*8+:8] = (c - i >= 0 && c - i < 8) ? 8'((c - i) * 16 + i) : 8'hEE;
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, w);
            if (c >= 3) begin
                @(negedge clk);
                chk($sformatf("dsk_allvalid_c%0d", c), int'(dv_d), 15);
                chk($sformatf("dsk_inflight_c%0d", c), int'(inf_d), 3);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("dsk_align_c%0d_ch%0d", c, i), int'(dout_d[i]), (c - 3) * 16 + i);
            end
            tick();
        end
        idle(4);

        // flush with three in flight and a wavefront presented
        step(1'b1, 1'b0, 1'b1, 32'hD3D2D1D0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hD7D6D5D4, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hDBDAD9D8, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("flush_dv", int'(dv_s), 0);
        chk("flush_inflight", int'(inf_s), 0);
        chk("flush_busy", int'(busy_s), 0);
        tick();
        idle(5);

        // async reset mid-stream with three in flight
        step(1'b1, 1'b0, 1'b1, 32'hE3E2E1E0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hE7E6E5E4, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hEBEAE9E8, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        clear_sb();
        acc_now = 2'b00;
        tick();
        rst_n = 1'b1;
        idle(6);
        step(1'b1, 1'b0, 1'b1, 32'h93929190, 1'b0, 32'h0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
